// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM configuration scheduler.
package pwm_pkg;

    localparam int DEF_CW  = 8;
    localparam int DEF_PSW = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ERR
    } sched_state_e;

    // The fields are sized by the package defaults. Resize a channel here, not at the instance.
    typedef struct packed {
        logic [DEF_CW-1:0]  period;
        logic [DEF_CW-1:0]  on_time;
        logic [DEF_PSW-1:0] prescale;
        logic               run;
    } ch_cfg_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Per-channel prescaler. It emits a tick every prescale_i+1 clocks while the channel runs.
module pwm_prescaler #(
    parameter int PSW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run_i,
    input  logic           clear_i,
    input  logic [PSW-1:0] prescale_i,
    output logic           tick_o
);

    logic [PSW-1:0] cnt_q;
    logic [PSW-1:0] cnt_d;

    assign tick_o = (cnt_q == prescale_i);

    // NOTE: a default comes first so every path assigns cnt_d and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !run_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PSW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_cfg_scheduler.sv
// Validates per-channel PWM config writes, shadows them, and commits them at period boundaries.
module pwm_cfg_scheduler
    import pwm_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  CW     = DEF_CW,
    parameter int  PSW    = DEF_PSW,
    localparam int CHW    = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CHW-1:0]       cfg_ch,
    input  logic [CW-1:0]        cfg_period,
    input  logic [CW-1:0]        cfg_on_time,
    input  logic [PSW-1:0]       cfg_prescale,
    input  logic                 cfg_run,
    input  logic [NUM_CH-1:0]    ch_wrap,
    output logic [NUM_CH-1:0]    ch_enable,
    output logic [NUM_CH*CW-1:0] ch_period,
    output logic [NUM_CH*CW-1:0] ch_on_time,
    output logic [NUM_CH-1:0]    pending,
    output logic [NUM_CH-1:0]    commit,
    output logic                 err
);

    sched_state_e      state_q;
    logic              ready_q;
    logic              err_q;
    ch_cfg_t           cap_q;
    logic [CHW-1:0]    cap_ch_q;
    logic [CW:0]       period_p1;
    logic              cap_ok;

    ch_cfg_t           shadow_q [NUM_CH];
    ch_cfg_t           live_q   [NUM_CH];
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] commit_q;
    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] wr_vec;
    logic [NUM_CH-1:0] commit_vec;
    logic [NUM_CH-1:0] tick;

    // The on_time limit is one past the period, so compare with an extra bit.
    assign period_p1 = {1'b0, cap_q.period} + (CW+1)'(1);
    assign cap_ok    = (cap_q.period != '0)
                    && ({1'b0, cap_q.on_time} <= period_p1)
                    && (int'(cap_ch_q) < NUM_CH);

    // NOTE: state is updated with non-blocking assignments so that every reader samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
            cap_q    <= '0;
            cap_ch_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    err_q <= 1'b0;
                    if (cfg_valid && ready_q) begin
                        cap_q    <= '{period: cfg_period, on_time: cfg_on_time,
                                      prescale: cfg_prescale, run: cfg_run};
                        cap_ch_q <= cfg_ch;
                        ready_q  <= 1'b0;
                        state_q  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (cap_ok) begin
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr_vec[g]     = (state_q == ST_CHECK) && cap_ok && (cap_ch_q == CHW'(g));
        assign commit_vec[g] = pending_q[g] && (ch_wrap[g] || !live_q[g].run);

        pwm_prescaler #(.PSW(PSW)) u_prescaler (
            .clk        (clk),
            .rst        (rst),
            .run_i      (live_q[g].run),
            .clear_i    (commit_vec[g]),
            .prescale_i (live_q[g].prescale),
            .tick_o     (tick[g])
        );

        assign ch_period[g*CW +: CW]  = live_q[g].period;
        assign ch_on_time[g*CW +: CW] = live_q[g].on_time;
    end

    // NOTE: shadow/live are small register banks rather than RAM, so every entry takes the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                live_q[i]   <= '0;
            end
            pending_q <= '0;
            commit_q  <= '0;
            en_q      <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // A commit colliding with a write takes the old shadow, and the write keeps pending set.
                if (commit_vec[i]) live_q[i]   <= shadow_q[i];
                if (wr_vec[i])     shadow_q[i] <= cap_q;
                pending_q[i] <= wr_vec[i] || (pending_q[i] && !commit_vec[i]);
                en_q[i]      <= live_q[i].run && tick[i];
            end
            commit_q <= commit_vec;
        end
    end

    assign cfg_ready = ready_q;
    assign err       = err_q;
    assign pending   = pending_q;
    assign commit    = commit_q;
    assign ch_enable = en_q;

endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// Directed bench for pwm_cfg_scheduler. NUM_CH=3 leaves channel index 3 free as an out-of-range target.
module tb_pwm_cfg_scheduler;

    localparam int NUM_CH = 3;
    localparam int CW     = 8;
    localparam int PSW    = 8;
    localparam int CHW    = $clog2(NUM_CH);

    logic                 clk;
    logic                 rst;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CHW-1:0]       cfg_ch;
    logic [CW-1:0]        cfg_period;
    logic [CW-1:0]        cfg_on_time;
    logic [PSW-1:0]       cfg_prescale;
    logic                 cfg_run;
    logic [NUM_CH-1:0]    ch_wrap;
    logic [NUM_CH-1:0]    ch_enable;
    logic [NUM_CH*CW-1:0] ch_period;
    logic [NUM_CH*CW-1:0] ch_on_time;
    logic [NUM_CH-1:0]    pending;
    logic [NUM_CH-1:0]    commit;
    logic                 err;

    int errors = 0;
    int checks = 0;

    pwm_cfg_scheduler #(.NUM_CH(NUM_CH), .CW(CW), .PSW(PSW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_period   (cfg_period),
        .cfg_on_time  (cfg_on_time),
        .cfg_prescale (cfg_prescale),
        .cfg_run      (cfg_run),
        .ch_wrap      (ch_wrap),
        .ch_enable    (ch_enable),
        .ch_period    (ch_period),
        .ch_on_time   (ch_on_time),
        .pending      (pending),
        .commit       (commit),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one write for a single cycle. The call returns in the CHECK cycle.
    task automatic write(input int ch, input int per, input int on, input int ps, input bit run);
        cfg_valid    = 1'b1;
        cfg_ch       = CHW'(ch);
        cfg_period   = CW'(per);
        cfg_on_time  = CW'(on);
        cfg_prescale = PSW'(ps);
        cfg_run      = run;
        step();
        cfg_valid    = 1'b0;
    endtask

    // Follows a rejected write from CHECK through ERR and back to IDLE.
    task automatic expect_reject(input string tag, input logic [NUM_CH-1:0] pend);
        check({tag, "_chk_ready"}, cfg_ready, 0);
        check({tag, "_chk_err"},   err,       0);
        step();
        check({tag, "_err_pulse"}, err,       1);
        check({tag, "_err_ready"}, cfg_ready, 0);
        step();
        check({tag, "_err_done"},  err,       0);
        check({tag, "_ready_back"}, cfg_ready, 1);
        check({tag, "_pending"},   pending,   pend);
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_period = '0;
        cfg_on_time = '0;
        cfg_prescale = '0;
        cfg_run   = 1'b0;
        ch_wrap   = '0;
        step(2);
        rst = 1'b0;
        step();

        // Reset state
        check("rst_ready",   cfg_ready,  1);
        check("rst_err",     err,        0);
        check("rst_pending", pending,    0);
        check("rst_commit",  commit,     0);
        check("rst_enable",  ch_enable,  0);
        check("rst_period",  ch_period,  0);
        check("rst_on_time", ch_on_time, 0);

        // 1: write to a stopped ch0 commits after three cycles
        write(0, 9, 5, 0, 1'b1);
        check("t1_check_ready",   cfg_ready, 0);
        check("t1_check_pending", pending,   3'b000);
        step();
        check("t1_pending",       pending,   3'b001);
        check("t1_ready_back",    cfg_ready, 1);
        check("t1_no_commit_yet", commit,    3'b000);
        check("t1_period_old",    ch_period[0 +: CW], 0);
        step();
        check("t1_commit",        commit,    3'b001);
        check("t1_period",        ch_period[0 +: CW],  9);
        check("t1_on_time",       ch_on_time[0 +: CW], 5);
        check("t1_pending_clr",   pending,   3'b000);
        check("t1_enable_first",  ch_enable, 3'b000);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t1_enable_every", ch_enable, 3'b001);
        end
        check("t1_commit_once", commit, 3'b000);

        // 2: a running channel holds its live config until ch_wrap
        write(0, 9, 2, 0, 1'b1);
        step();
        check("t2_pending", pending, 3'b001);
        step(3);
        check("t2_held_on_time", ch_on_time[0 +: CW], 5);
        check("t2_held_commit",  commit,  3'b000);
        check("t2_held_pending", pending, 3'b001);
        ch_wrap = 3'b001;
        step();
        ch_wrap = 3'b000;
        check("t2_commit",      commit,  3'b001);
        check("t2_on_time",     ch_on_time[0 +: CW], 2);
        check("t2_pending_clr", pending, 3'b000);
        step();
        check("t2_commit_pulse", commit, 3'b000);
        ch_wrap = 3'b001;
        step();
        ch_wrap = 3'b000;
        step();
        check("t2_idle_wrap_commit", commit, 3'b000);
        check("t2_idle_wrap_enable", ch_enable[0], 1);

        // 3: prescale 3 on ch1 gives one enable in every four clocks
        write(1, 10, 3, 3, 1'b1);
        step(2);
        check("t3_commit", commit, 3'b010);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("t3_enable_k%0d", k), ch_enable[1], (k >= 4 && (k % 4) == 0));
            step();
        end

        // 4: rejected writes, followed by the on_time == period+1 boundary being accepted
        write(1, 0, 0, 0, 1'b1);
        expect_reject("t4_period0", 3'b000);
        write(1, 4, 6, 0, 1'b1);
        expect_reject("t4_on_gt", 3'b000);
        write(3, 5, 1, 0, 1'b1);
        expect_reject("t4_bad_ch", 3'b000);
        write(1, 4, 5, 3, 1'b1);
        step();
        check("t4_edge_err",     err,     0);
        check("t4_edge_pending", pending, 3'b010);
        check("t4_edge_live",    ch_period[1*CW +: CW], 10);

        // 5: the latest shadow wins, and a collision leaves pending set
        write(2, 8, 1, 0, 1'b1);
        step(2);
        check("t5_start_commit", commit, 3'b100);
        check("t5_start_on",     ch_on_time[2*CW +: CW], 1);
        write(2, 8, 3, 0, 1'b1);
        step();
        check("t5_pend_a", pending[2], 1);
        write(2, 8, 7, 0, 1'b1);
        step();
        check("t5_pend_b", pending[2], 1);
        check("t5_live_held", ch_on_time[2*CW +: CW], 1);
        ch_wrap = 3'b100;
        step();
        ch_wrap = 3'b000;
        check("t5_commit",  commit, 3'b100);
        check("t5_on_time", ch_on_time[2*CW +: CW], 7);
        step();
        check("t5_single_commit", commit, 3'b000);
        check("t5_pend_clr", pending[2], 0);
        write(2, 8, 5, 0, 1'b1);
        step();
        write(2, 8, 6, 0, 1'b1);
        ch_wrap = 3'b100;
        step();
        ch_wrap = 3'b000;
        check("t5_coll_commit",  commit, 3'b100);
        check("t5_coll_on_time", ch_on_time[2*CW +: CW], 5);
        check("t5_coll_pending", pending[2], 1);
        ch_wrap = 3'b100;
        step();
        ch_wrap = 3'b000;
        check("t5_final_on_time", ch_on_time[2*CW +: CW], 6);
        check("t5_final_pending", pending[2], 0);

        // 6: reset asserted during CHECK of an invalid write
        write(0, 0, 1, 0, 1'b1);
        check("t6_in_check", cfg_ready, 0);
        rst = 1'b1;
        #1;
        check("t6_ready",   cfg_ready,  1);
        check("t6_err",     err,        0);
        check("t6_enable",  ch_enable,  0);
        check("t6_period",  ch_period,  0);
        check("t6_on_time", ch_on_time, 0);
        check("t6_pending", pending,    0);
        check("t6_commit",  commit,     0);
        step(2);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t6_no_err",    err,       0);
            check("t6_idle",      cfg_ready, 1);
            check("t6_no_enable", ch_enable, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
